// File: rtl/mem_fifo_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_fifo_loader_pkg
// Description : Shared matrix-vector constants, FIFO index type and the
//               loader state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_fifo_loader_pkg;

  // Default geometry shared with the multiplier and its FIFO array
  localparam int c_NUM_ROWS = 8;
  localparam int c_DATA_W   = 8;
  localparam int c_WORD_W   = 64;
  localparam int c_ADDR_W   = 32;
  localparam int c_BPW      = c_WORD_W / c_DATA_W;

  // Index into the NUM_ROWS+1 input FIFOs (vector FIFO is the last one)
  typedef logic [$clog2(c_NUM_ROWS + 1)-1:0] fifo_idx_t;

  // Loader FSM encoding
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ       = 3'd1,
    S_WAIT_DATA = 3'd2,
    S_UNPACK    = 3'd3,
    S_DONE      = 3'd4
  } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_fifo_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_fifo_loader_if
// Description : Control, memory-read and FIFO-write signals of the loader.
//               master = loader side, slave = memory/FIFO/controller side.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_fifo_loader_if #(
  parameter int NUM_ROWS = 8,
  parameter int DATA_W   = 8,
  parameter int WORD_W   = 64,
  parameter int ADDR_W   = 32
) ();

  logic                fill;
  logic                busy;
  logic                done;
  logic [ADDR_W-1:0]   mem_address;
  logic                mem_read;
  logic                mem_waitrequest;
  logic [WORD_W-1:0]   mem_readdata;
  logic                mem_readdatavalid;
  logic [NUM_ROWS:0]   fifo_sel;
  logic [DATA_W-1:0]   fifo_din;
  logic                fifo_wren;
  logic [NUM_ROWS:0]   fifo_full;

  modport master (
    input  fill,
    output busy,
    output done,
    output mem_address,
    output mem_read,
    input  mem_waitrequest,
    input  mem_readdata,
    input  mem_readdatavalid,
    output fifo_sel,
    output fifo_din,
    output fifo_wren,
    input  fifo_full
  );

  modport slave (
    output fill,
    input  busy,
    input  done,
    input  mem_address,
    input  mem_read,
    output mem_waitrequest,
    output mem_readdata,
    output mem_readdatavalid,
    input  fifo_sel,
    input  fifo_din,
    input  fifo_wren,
    output fifo_full
  );

endinterface
`default_nettype wire

// File: rtl/mem_fifo_loader_word_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : mem_fifo_loader_word_unpacker
// Description : Holds one memory word and presents it one element at a time,
//               least-significant element first, flagging the last one.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_fifo_loader_word_unpacker #(
  parameter int DATA_W = 8,
  parameter int WORD_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WORD_W-1:0] word_in,
  input  logic              advance,
  output logic [DATA_W-1:0] byte_out,
  output logic              last_byte
);

  localparam int c_BPW    = WORD_W / DATA_W;
  localparam int c_BIDX_W = $clog2(c_BPW);

  typedef logic [c_BIDX_W-1:0] bidx_t;

  logic [c_BPW-1:0][DATA_W-1:0] r_word_q;
  bidx_t                        r_byte_idx;

  // Capture a fresh word (restarting at element 0) or step to the next element
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_q   <= '0;
      r_byte_idx <= '0;
    end else if (load) begin
      r_word_q   <= word_in;
      r_byte_idx <= '0;
    end else if (advance) begin
      r_byte_idx <= last_byte ? '0 : r_byte_idx + bidx_t'(1);
    end
  end

  assign byte_out  = r_word_q[r_byte_idx];
  assign last_byte = (r_byte_idx == bidx_t'(c_BPW - 1));

endmodule
`default_nettype wire

// File: rtl/mem_fifo_loader.sv
`default_nettype none
// ============================================================================
// Module      : mem_fifo_loader
// Description : On a fill pulse reads NUM_ROWS matrix rows plus one vector
//               word from memory and scatters their bytes into the one-hot
//               selected input FIFOs, honouring FIFO full back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_fifo_loader
  import mem_fifo_loader_pkg::*;
#(
  parameter int                NUM_ROWS  = c_NUM_ROWS,
  parameter int                DATA_W    = c_DATA_W,
  parameter int                WORD_W    = c_WORD_W,
  parameter int                ADDR_W    = c_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_fifo_loader_if.master   bus
);

  localparam int c_IDX_W = $clog2(NUM_ROWS + 1);

  typedef logic [c_IDX_W-1:0] widx_t;

  loader_state_t      r_state;
  loader_state_t      w_state_nxt;
  widx_t              r_word_idx;
  widx_t              w_word_idx_nxt;

  logic               w_load;
  logic               w_advance;
  logic               w_last_byte;
  logic [DATA_W-1:0]  w_byte;

  logic               w_busy;
  logic               w_done;
  logic               w_mem_read;
  logic [ADDR_W-1:0]  w_mem_address;
  logic [NUM_ROWS:0]  w_fifo_sel;
  logic [DATA_W-1:0]  w_fifo_din;
  logic               w_fifo_wren;

  mem_fifo_loader_word_unpacker #(
    .DATA_W (DATA_W),
    .WORD_W (WORD_W)
  ) u_unpacker (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (w_load),
    .word_in   (bus.mem_readdata),
    .advance   (w_advance),
    .byte_out  (w_byte),
    .last_byte (w_last_byte)
  );

  // State and word counter; async reset parks the loader in IDLE at row 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_word_idx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_word_idx <= w_word_idx_nxt;
    end
  end

  // Next-state and outputs; select/data are only driven while unpacking
  always_comb begin
    w_state_nxt    = r_state;
    w_word_idx_nxt = r_word_idx;
    w_load         = 1'b0;
    w_advance      = 1'b0;
    w_busy         = 1'b1;
    w_done         = 1'b0;
    w_mem_read     = 1'b0;
    w_mem_address  = '0;
    w_fifo_sel     = '0;
    w_fifo_din     = '0;
    w_fifo_wren    = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.fill) begin
          w_state_nxt    = S_REQ;
          w_word_idx_nxt = '0;
        end
      end

      S_REQ: begin
        w_mem_read    = 1'b1;
        w_mem_address = BASE_ADDR + ADDR_W'(r_word_idx);
        if (!bus.mem_waitrequest) begin
          w_state_nxt = S_WAIT_DATA;
        end
      end

      S_WAIT_DATA: begin
        // Only one read is ever outstanding, so the first valid beat is ours
        if (bus.mem_readdatavalid) begin
          w_load      = 1'b1;
          w_state_nxt = S_UNPACK;
        end
      end

      S_UNPACK: begin
        w_fifo_sel[r_word_idx] = 1'b1;
        w_fifo_din             = w_byte;
        w_fifo_wren            = ~bus.fifo_full[r_word_idx];
        w_advance              = w_fifo_wren;
        if (w_fifo_wren && w_last_byte) begin
          w_word_idx_nxt = r_word_idx + widx_t'(1);
          w_state_nxt    = (r_word_idx == widx_t'(NUM_ROWS)) ? S_DONE : S_REQ;
        end
      end

      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.mem_read    = w_mem_read;
  assign bus.mem_address = w_mem_address;
  assign bus.fifo_sel    = w_fifo_sel;
  assign bus.fifo_din    = w_fifo_din;
  assign bus.fifo_wren   = w_fifo_wren;

endmodule
`default_nettype wire
